// File: rtl/key_cond_pkg.sv
// Shared defaults, counter sizing and the per-channel event bundle
// used by the key conditioner.
package key_cond_pkg;

  localparam int DEF_N_KEYS          = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_REPEAT_CYCLES   = 0;
  localparam bit DEF_ACTIVE_LOW      = 1'b1;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic strobe;
  } key_evt_t;

  // max(1, $clog2(n)): a counter never collapses to zero bits
  function automatic int cnt_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_cond_chan.sv
// One key channel: N-flop synchroniser, stable-count debouncer and
// press/release edge detector with optional auto-repeat strobe.
module key_cond_chan
  import key_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_key,
  output key_evt_t o_evt
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RW = cnt_width(REPEAT_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RMAX = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{ACTIVE_LOW}};

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DW-1:0]          r_dcnt;
  logic                   r_level;
  logic                   r_press;
  logic                   r_rel;
  logic                   r_strobe;
  logic                   w_s;
  logic                   w_flip;

  // synced sample normalised so that 1 always means pressed
  assign w_s    = ACTIVE_LOW ? ~r_sync[SYNC_STAGES-1] : r_sync[SYNC_STAGES-1];
  assign w_flip = (w_s != r_level) && (r_dcnt == DMAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= SYNC_IDLE;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_key};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dcnt  <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_press <= 1'b0;
      r_rel   <= 1'b0;
      if (w_s == r_level) begin
        r_dcnt <= '0;
      end else if (w_flip) begin
        r_level <= w_s;
        r_dcnt  <= '0;
        r_press <= w_s;
        r_rel   <= ~w_s;
      end else begin
        r_dcnt <= r_dcnt + DW'(1);
      end
    end
  end

  generate
    if (REPEAT_CYCLES > 0) begin : g_rep
      logic [RW-1:0] r_rcnt;

      // a release edge takes priority over a repeat tick falling due on it
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_rcnt   <= '0;
          r_strobe <= 1'b0;
        end else if (w_flip) begin
          r_rcnt   <= '0;
          r_strobe <= w_s;
        end else if (r_level) begin
          if (r_rcnt == RMAX) begin
            r_rcnt   <= '0;
            r_strobe <= 1'b1;
          end else begin
            r_rcnt   <= r_rcnt + RW'(1);
            r_strobe <= 1'b0;
          end
        end else begin
          r_rcnt   <= '0;
          r_strobe <= 1'b0;
        end
      end
    end else begin : g_norep
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_strobe <= 1'b0;
        else          r_strobe <= w_flip & w_s;
      end
    end
  endgenerate

  assign o_evt.level  = r_level;
  assign o_evt.press  = r_press;
  assign o_evt.rel    = r_rel;
  assign o_evt.strobe = r_strobe;

endmodule

// File: rtl/key_conditioner.sv
// Multi-channel push-button/switch front end: N_KEYS independent
// synchronise/debounce/edge-detect channels between raw pins and control.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int N_KEYS          = DEF_N_KEYS,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] level,
  output logic [N_KEYS-1:0] press,
  // `release` is a reserved word, so the release pulse carries a suffix
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] strobe
);

  generate
    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
      key_evt_t w_evt;

      key_cond_chan #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_chan (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_key   (KEY[i]),
        .o_evt   (w_evt)
      );

      assign level[i]         = w_evt.level;
      assign press[i]         = w_evt.press;
      assign release_pulse[i] = w_evt.rel;
      assign strobe[i]        = w_evt.strobe;
    end
  endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: SYNC=2, DEB=4, REPEAT=8, active-low keys.
module tb_key_conditioner;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] KEY   = 4'b0000;
  logic [3:0] level, press, release_pulse, strobe;
  logic [15:0] w_obs;
  int n_chk = 0;
  int n_err = 0;

  key_conditioner #(
    .N_KEYS          (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (8),
    .ACTIVE_LOW      (1'b1)
  ) u_dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .KEY           (KEY),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .strobe        (strobe)
  );

  always #5 Clock = ~Clock;

  assign w_obs = {level, press, release_pulse, strobe};

  function automatic logic [15:0] ev(input logic [3:0] l, p, r, s);
    return {l, p, r, s};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h (level,press,release,strobe)", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // n edges: the first n-1 must show mid, the n-th must show fin
  task automatic wait_chk(input string tag, input int n, input logic [15:0] mid,
                          input logic [15:0] fin);
    for (int k = 1; k < n; k++) begin
      tick();
      chk($sformatf("%s[%0d]", tag, k), w_obs, mid);
    end
    tick();
    chk($sformatf("%s[%0d]", tag, n), w_obs, fin);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    // reset with all keys "pressed", then exit with all released
    #1;
    chk("rst_t0", w_obs, 16'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst_hold[%0d]", k), w_obs, 16'h0);
    end
    KEY   = 4'b1111;
    Reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rst_exit[%0d]", k), w_obs, 16'h0);
    end

    // single press on key 0, level rises 5 edges after the sampling edge
    KEY = 4'b1110;
    wait_chk("p0", 6, 16'h0, ev(4'b0001, 4'b0001, 4'b0000, 4'b0001));
    KEY = 4'b1111;
    wait_chk("r0", 6, ev(4'b0001, 4'b0, 4'b0, 4'b0), ev(4'b0, 4'b0, 4'b0001, 4'b0));
    tick();
    chk("r0_idle", w_obs, 16'h0);

    // bounce on key 1 never settles long enough
    for (int k = 0; k < 20; k++) begin
      KEY[1] = k[0];
      tick();
      chk($sformatf("bounce[%0d]", k), w_obs, 16'h0);
    end
    KEY[1] = 1'b0;
    wait_chk("p1", 6, 16'h0, ev(4'b0010, 4'b0010, 4'b0000, 4'b0010));
    KEY[1] = 1'b1;
    wait_chk("r1", 6, ev(4'b0010, 4'b0, 4'b0, 4'b0), ev(4'b0, 4'b0, 4'b0010, 4'b0));

    // auto-repeat on key 2; release lands exactly on a due repeat tick
    KEY[2] = 1'b0;
    wait_chk("p2", 6, 16'h0, ev(4'b0100, 4'b0100, 4'b0000, 4'b0100));
    for (int k = 1; k <= 42; k++) begin
      logic [3:0] el, er, es;
      if (k == 35) KEY[2] = 1'b1;
      tick();
      el = (k < 40) ? 4'b0100 : 4'b0000;
      es = (k < 40 && (k % 8) == 0) ? 4'b0100 : 4'b0000;
      er = (k == 40) ? 4'b0100 : 4'b0000;
      chk($sformatf("rep[%0d]", k), w_obs, ev(el, 4'b0000, er, es));
    end

    // keys 0 and 3 on the same edge
    KEY = 4'b0110;
    wait_chk("p03", 6, 16'h0, ev(4'b1001, 4'b1001, 4'b0000, 4'b1001));
    KEY = 4'b1111;
    wait_chk("r03", 6, ev(4'b1001, 4'b0, 4'b0, 4'b0), ev(4'b0, 4'b0, 4'b1001, 4'b0));
    tick();
    chk("r03_idle", w_obs, 16'h0);

    // reset mid-debounce (count at 2) forces the full count again
    KEY[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("pre_rst[%0d]", k), w_obs, 16'h0);
    end
    Reset = 1'b0;
    #1;
    chk("rst_async", w_obs, 16'h0);
    tick();
    chk("rst_mid", w_obs, 16'h0);
    Reset = 1'b1;
    wait_chk("p0_redo", 6, 16'h0, ev(4'b0001, 4'b0001, 4'b0000, 4'b0001));
    tick();
    chk("p0_redo_hold", w_obs, ev(4'b0001, 4'b0, 4'b0, 4'b0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Parametrised multi-channel front end for board push-buttons and switches, generalising the existing two-flop key synchroniser.
- Per channel, it runs three steps in order:
  - an N-stage metastability synchroniser;
  - a stable-count debouncer;
  - an edge detector with optional auto-repeat.
- Sits between the raw KEY/SW pins and the Game-of-Life control FSM (cursor step, run/pause, single-step).
- Each channel is independent.

Parameters:
- N_KEYS, 4: number of independent input channels (>=1).
- SYNC_STAGES, 2: synchroniser flop depth (>=2).
- DEBOUNCE_CYCLES, 50000: consecutive identical synced samples required before the debounced level changes (>=1).
- REPEAT_CYCLES, 0: auto-repeat period in cycles while held; 0 disables repeat (>=0).
- ACTIVE_LOW, 1: 1 means raw pin reads 0 when pressed (DE1 KEYs); 0 means active-high.

Ports:
- Clock, input, 1: single system clock; all state is on posedge Clock.
- Reset, input, 1: asynchronous, active-low reset. Deassertion is synchronised upstream.
- KEY, input, N_KEYS: raw asynchronous pin inputs.
- level, output, N_KEYS: debounced pressed state; 1 = pressed, regardless of ACTIVE_LOW.
- press, output, N_KEYS: 1-cycle pulse on debounced press edge only.
- release, output, N_KEYS: 1-cycle pulse on debounced release edge.
- strobe, output, N_KEYS: 1-cycle pulse on press edge and on every auto-repeat tick.

Behaviour:
- Reset (Reset=0) takes effect immediately, without a clock:
  - synchroniser stages reset to the idle pin value (ACTIVE_LOW ? 1 : 0);
  - debounce state = not pressed;
  - all counters = 0;
  - level, press, release, strobe = 0.
- Reset asserted mid-debounce or mid-repeat discards the partial count. No pulse is emitted on reset entry or exit.
- Synchroniser:
  - KEY[i] is sampled into stage 1; the value appears at the last stage SYNC_STAGES-1 edges later.
  - The synced value s[i] is normalised to pressed-high: s = ACTIVE_LOW ? ~stage_last : stage_last.
- Debouncer, per channel. Counter dcnt has width max(1, $clog2(DEBOUNCE_CYCLES)). On each edge:
  - If s == level: dcnt <= 0.
  - Else if dcnt == DEBOUNCE_CYCLES-1: level <= s, dcnt <= 0, and press (s=1) or release (s=0) asserts for exactly the next cycle.
  - Else: dcnt <= dcnt+1.
  - Any glitch back to the current level clears dcnt.
- Latency: a pin change sampled at edge e changes level at edge e + SYNC_STAGES - 1 + DEBOUNCE_CYCLES. press/release assert in the same cycle level changes.
- Auto-repeat, only when REPEAT_CYCLES > 0. Counter rcnt has width max(1, $clog2(REPEAT_CYCLES)).
  - On the press edge: rcnt <= 0.
  - While level=1: rcnt increments each edge. When rcnt == REPEAT_CYCLES-1, strobe pulses for one cycle and rcnt <= 0.
  - While level=0: rcnt is held at 0.
  - The first repeat strobe occurs REPEAT_CYCLES cycles after the press strobe.
- strobe = press | repeat tick, registered. Release never produces a strobe.
- When REPEAT_CYCLES = 0, strobe equals press.
- Boundary cases:
  - DEBOUNCE_CYCLES=1: level follows s with 1 cycle delay.
  - Release while a repeat tick is due: the release wins and no strobe is emitted.
  - Simultaneous activity on several channels is handled fully independently, with no priority.
- Outputs are glitch-free registers; no combinational path from KEY to any output.

Decomposition:
- Package key_cond_pkg holds:
  - the default parameter constants (default SYNC_STAGES, DEBOUNCE_CYCLES, REPEAT_CYCLES);
  - function cnt_width(n), returning max(1, $clog2(n)).
- Sub-module key_cond_chan: one channel (sync chain, debouncer, repeat).
- key_conditioner instantiates N_KEYS copies in a generate loop.

Test Plan:
- Reset asserted with KEY=4'b0000, then released with KEY=4'b1111 (ACTIVE_LOW=1, DEBOUNCE_CYCLES=4) -> all outputs 0 during and after reset; no press pulse.
- KEY[0] driven 1->0 at edge e, held (SYNC=2, DEB=4) -> level[0] rises at edge e+5; press[0]=1 and strobe[0]=1 for exactly that cycle; release=0.
- KEY[1] bounces 0,1,0,1 on alternate cycles for 20 cycles, then held 0 -> no press during bounce; a single press 5 edges after the final stable sample.
- REPEAT_CYCLES=8, KEY[2] held pressed for 30 cycles after level rises -> strobe[2] at cycles 0, 8, 16, 24 relative to press; press[2] only at cycle 0; on release, one release[2] pulse and no strobe.
- KEY[0] and KEY[3] pressed on the same edge -> both level bits rise on the same edge, each with its own press pulse.
- Reset pulsed low mid-debounce (dcnt=2) -> level stays 0, dcnt cleared; after reset the full 4-sample count is required again.
